// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit and the control unit.
package muldiv_pkg;

    localparam logic [3:0] FUNC_MUL = 4'b1000;
    localparam logic [3:0] FUNC_DIV = 4'b0100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/muldiv_core.sv
// Shared accumulator/remainder datapath: one shift-add (multiply) or
// restoring shift-subtract (divide) step per strobe, on unsigned magnitudes.
module muldiv_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH:0]   load_op,
    input  logic [WIDTH-1:0] load_lo,
    output logic [WIDTH:0]   acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [WIDTH:0]   operand;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // acc_hi never exceeds WIDTH magnitude bits, so sum and shifted cannot overflow WIDTH+1 bits
    always_comb begin
        sum     = acc_hi + (acc_lo[0] ? operand : '0);
        shifted = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        diff    = {1'b0, shifted} - {1'b0, operand};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_hi  <= '0;
            acc_lo  <= '0;
            operand <= '0;
        end else if (load) begin
            acc_hi  <= '0;
            acc_lo  <= load_lo;
            operand <= load_op;
        end else if (step) begin
            if (is_div) begin
                if (!diff[WIDTH+1]) begin
                    acc_hi <= diff[WIDTH:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= shifted;
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                {acc_hi, acc_lo} <= {1'b0, sum, acc_lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply/divide sequencer: latches operands, drives the
// core through SETUP/RUN/FIX and returns low/high words with error flags.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             req;
    logic [WIDTH:0]   mag_a;
    logic [WIDTH:0]   mag_b;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;

    // Sign-extend by one bit first so that MIN maps to +2^(WIDTH-1)
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] ext;
        ext = {v[WIDTH-1], v};
        return v[WIDTH-1] ? -ext : ext;
    endfunction

    function automatic logic [WIDTH-1:0] sign_word(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] sign_dword(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        req   = start && (func == FUNC_MUL || func == FUNC_DIV);
        busy  = (state != ST_IDLE && state != ST_DONE) || (state == ST_IDLE && req);
        mag_a = magnitude(a_q);
        mag_b = magnitude(b_q);
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req) begin
            a_q    <= op_a;
            b_q    <= op_b;
            is_div <= (func == FUNC_DIV);
            neg_lo <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_hi <= op_a[WIDTH-1];
        end
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .reset   (reset),
        .load    (state == ST_SETUP),
        .step    (state == ST_RUN),
        .is_div  (is_div),
        .load_op (is_div ? mag_b : mag_a),
        .load_lo (is_div ? mag_a[WIDTH-1:0] : mag_b[WIDTH-1:0]),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            overflow <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (req) state <= ST_SETUP;
                    ST_SETUP: begin
                        if (is_div && b_q == '0) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            div_zero  <= 1'b1;
                            result_lo <= '0;
                            result_hi <= a_q;
                        end else if (is_div && a_q == MIN_VAL && b_q == '1) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            overflow  <= 1'b1;
                            result_lo <= MIN_VAL;
                            result_hi <= '0;
                        end else begin
                            state <= ST_RUN;
                            cnt   <= CNT_W'(WIDTH - 1);
                        end
                    end
                    ST_RUN: begin
                        if (cnt == '0) state <= ST_FIX;
                        else           cnt   <= cnt - 1'b1;
                    end
                    ST_FIX: begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        if (is_div) begin
                            result_lo <= sign_word(acc_lo, neg_lo);
                            result_hi <= sign_word(acc_hi[WIDTH-1:0], neg_hi);
                        end else begin
                            {result_hi, result_lo} <= sign_dword({acc_hi[WIDTH-1:0], acc_lo}, neg_lo);
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
